// File: rtl/ssd_scanner.sv
// Time-multiplexed seven-segment scanner with per-frame input snapshot,
// per-slot dead time and leading-zero blanking. All outputs are registered.
module ssd_scanner #(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV_BITS = 18,
  parameter int BLANK_CYCLES  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SCAN_DIV_BITS-1:0] BLANK_W = SCAN_DIV_BITS'(BLANK_CYCLES);

  logic [SCAN_DIV_BITS-1:0] pre_q, pre_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]  digits_q, digits_d;
  logic [NUM_DIGITS-1:0]    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]    en_q, en_d;
  logic                     lz_q, lz_d;
  logic                     started_q, started_d;
  logic [NUM_DIGITS-1:0]    an_q, an_d;
  logic [7:0]               seg_q, seg_d;
  logic                     tick_q, tick_d;

  logic                     wrap_s;
  logic                     snap_s;
  logic [3:0]               nib_s;
  logic [NUM_DIGITS-1:0]    blank_s;
  logic                     zero_run_s;

  // Hex nibble to active-low {a,b,c,d,e,f,g}
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b0000001;
      4'h1:    pat = 7'b1001111;
      4'h2:    pat = 7'b0010010;
      4'h3:    pat = 7'b0000110;
      4'h4:    pat = 7'b1001100;
      4'h5:    pat = 7'b0100100;
      4'h6:    pat = 7'b0100000;
      4'h7:    pat = 7'b0001111;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0000100;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b1100000;
      4'hC:    pat = 7'b0110001;
      4'hD:    pat = 7'b1000010;
      4'hE:    pat = 7'b0110000;
      4'hF:    pat = 7'b0111000;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // Leading-zero mask: a digit blanks only if it and every digit above it are zero with dp off
  always_comb begin
    zero_run_s = 1'b1;
    blank_s    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s && (digits_q[4*i +: 4] == 4'h0) && !dp_q[i];
      blank_s[i] = lz_q && (i != 0) && zero_run_s;
    end
  end

  // Scan sequencing, snapshot capture and next output pattern
  always_comb begin
    wrap_s    = (pre_q == '1) && (idx_q == LAST_IDX);
    snap_s    = wrap_s || !started_q;
    pre_d     = pre_q + SCAN_DIV_BITS'(1'b1);
    started_d = 1'b1;
    tick_d    = snap_s;
    nib_s     = digits_q[{idx_q, 2'b00} +: 4];

    if (pre_q == '1) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1'b1);
    end else begin
      idx_d = idx_q;
    end

    if (snap_s) begin
      digits_d = digits_in;
      dp_d     = dp_in;
      en_d     = digit_en;
      lz_d     = lz_blank;
    end else begin
      digits_d = digits_q;
      dp_d     = dp_q;
      en_d     = en_q;
      lz_d     = lz_q;
    end

    an_d  = '1;
    seg_d = 8'hFF;
    if (pre_q < BLANK_W) begin
      an_d  = '1;
      seg_d = 8'hFF;
    end else if (!en_q[idx_q] || blank_s[idx_q]) begin
      an_d  = '1;
      seg_d = 8'hFF;
    end else begin
      an_d[idx_q] = 1'b0;
      seg_d       = {seg7_decode(nib_s), ~dp_q[idx_q]};
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q     <= '0;
      idx_q     <= '0;
      digits_q  <= '0;
      dp_q      <= '0;
      en_q      <= '0;
      lz_q      <= 1'b0;
      started_q <= 1'b0;
      an_q      <= '1;
      seg_q     <= 8'hFF;
      tick_q    <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      digits_q  <= digits_d;
      dp_q      <= dp_d;
      en_q      <= en_d;
      lz_q      <= lz_d;
      started_q <= started_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      tick_q    <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_scanner.sv
// Bench for ssd_scanner (4 digits, 16-cycle slots, 2 dead cycles): an edge-count
// model checked every cycle, plus hand-computed literal expectations.
module tb_ssd_scanner;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;
  int k_tb     = 0;
  logic chk_en = 1'b0;

  ssd_scanner #(.NUM_DIGITS(4), .SCAN_DIV_BITS(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
    .digit_en(digit_en), .lz_blank(lz_blank), .an(an), .seg(seg),
    .frame_tick(frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Model state: m_k = rising edges seen with rst_n high since the last reset edge
  int          m_k;
  logic [15:0] m_dig;
  logic [3:0]  m_dp, m_en;
  logic        m_lz;
  logic [3:0]  exp_an;
  logic [7:0]  exp_seg;
  logic        exp_tick;

  always @(posedge clk) begin : model
    int pre, slot;
    logic blank, snap;
    logic [3:0] nan;
    logic [7:0] nseg;
    if (!rst_n) begin
      m_k <= 0; m_dig <= 16'h0; m_dp <= 4'h0; m_en <= 4'h0; m_lz <= 1'b0;
      exp_an <= 4'hF; exp_seg <= 8'hFF; exp_tick <= 1'b0;
    end else begin
      pre   = m_k % 16;
      slot  = (m_k / 16) % 4;
      blank = m_lz && (slot > 0) && ((m_dig >> (4 * slot)) == 16'h0) && ((m_dp >> slot) == 4'h0);
      nan   = 4'hF;
      nseg  = 8'hFF;
      if (pre >= 2 && m_en[slot] && !blank) begin
        nan[slot] = 1'b0;
        nseg = {SEG_TAB[m_dig[4*slot +: 4]], ~m_dp[slot]};
      end
      snap = (m_k == 0) || (m_k % 64 == 63);
      exp_an   <= nan;
      exp_seg  <= nseg;
      exp_tick <= snap;
      if (snap) begin
        m_dig <= digits_in; m_dp <= dp_in; m_en <= digit_en; m_lz <= lz_blank;
      end
      m_k <= m_k + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s t=%0t k=%0d actual=%h required=%h", name, $time, k_tb, act, expv);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_an",   32'(an),         32'(exp_an));
      check("model_seg",  32'(seg),        32'(exp_seg));
      check("model_tick", 32'(frame_tick), 32'(exp_tick));
      check("an_onehot",  32'($countones(~an) <= 1), 32'd1);
    end
  end

  task automatic adv_to(input int target);
    while (k_tb < target) begin
      @(negedge clk);
      k_tb++;
    end
  endtask

  task automatic reset_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e, input logic l);
    rst_n = 1'b0; digits_in = d; dp_in = p; digit_en = e; lz_blank = l;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_an",   32'(an),         32'hF);
    check("rst_seg",  32'(seg),        32'hFF);
    check("rst_tick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;
    k_tb  = 0;
  endtask

  initial begin
    rst_n = 1'b0; digits_in = 16'h0; dp_in = 4'h0; digit_en = 4'h0; lz_blank = 1'b0;

    // Plain 1234 display
    reset_load(16'h1234, 4'h0, 4'hF, 1'b0);
    adv_to(1);   check("first_tick", 32'(frame_tick), 32'h1);
                 check("dead_k1_an", 32'(an), 32'hF);
    adv_to(2);   check("dead_k2_an", 32'(an), 32'hF);
                 check("tick_k2", 32'(frame_tick), 32'h0);
    adv_to(3);   check("d0_an", 32'(an), 32'hE);  check("d0_seg", 32'(seg), 32'h99);
    adv_to(20);  check("d1_an", 32'(an), 32'hD);  check("d1_seg", 32'(seg), 32'h0D);
    adv_to(60);  check("d3_an", 32'(an), 32'h7);  check("d3_seg", 32'(seg), 32'h9F);
    adv_to(64);  check("tick_64", 32'(frame_tick), 32'h1);
    adv_to(65);  check("tick_65", 32'(frame_tick), 32'h0);
    adv_to(128); check("tick_128", 32'(frame_tick), 32'h1);

    // Leading-zero blanking and mid-frame input change
    reset_load(16'h0007, 4'h0, 4'hF, 1'b1);
    adv_to(3);   check("lz7_an", 32'(an), 32'hE);  check("lz7_seg", 32'(seg), 32'h1F);
    adv_to(5);   digits_in = 16'h0000;
    adv_to(10);  check("hold_seg", 32'(seg), 32'h1F);
    adv_to(20);  check("lz_s1_an", 32'(an), 32'hF); check("lz_s1_seg", 32'(seg), 32'hFF);
    adv_to(40);  check("lz_s2_an", 32'(an), 32'hF);
    adv_to(67);  check("zero_an", 32'(an), 32'hE);  check("zero_seg", 32'(seg), 32'h03);
    adv_to(84);  check("zero_s1_an", 32'(an), 32'hF);

    // Decimal point stops blanking below it
    reset_load(16'h0007, 4'b0100, 4'hF, 1'b1);
    adv_to(20);  check("dp_s1_an", 32'(an), 32'hD);  check("dp_s1_seg", 32'(seg), 32'h03);
    adv_to(35);  check("dp_s2_an", 32'(an), 32'hB);  check("dp_s2_seg", 32'(seg), 32'h02);
    adv_to(55);  check("dp_s3_an", 32'(an), 32'hF);  check("dp_s3_seg", 32'(seg), 32'hFF);

    // Per-digit enable
    reset_load(16'h1234, 4'h0, 4'b0101, 1'b0);
    adv_to(20);  check("en_s1_an", 32'(an), 32'hF);  check("en_s1_seg", 32'(seg), 32'hFF);
    adv_to(35);  check("en_s2_an", 32'(an), 32'hB);  check("en_s2_seg", 32'(seg), 32'h25);
    adv_to(36);

    // One-cycle reset in slot 2, new snapshot afterwards
    rst_n = 1'b0; digits_in = 16'h00A0; digit_en = 4'hF;
    @(negedge clk);
    check("mr_an", 32'(an), 32'hF); check("mr_seg", 32'(seg), 32'hFF);
    check("mr_tick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1; k_tb = 0;
    adv_to(1);   check("mr_first_tick", 32'(frame_tick), 32'h1);
    adv_to(3);   check("mr_d0_an", 32'(an), 32'hE); check("mr_d0_seg", 32'(seg), 32'h03);
    adv_to(20);  check("mr_d1_an", 32'(an), 32'hD); check("mr_d1_seg", 32'(seg), 32'h11);
    adv_to(70);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
